// File: rtl/tx_timing_pkg.sv
// Shared transmit-chain timing types and default rate constants, used by the
// scheduler and by the filter and measurement blocks that follow its cadence.
package tx_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } tx_state_t;

  localparam int SAM_LOG2_DEF   = 2;
  localparam int SYM_LOG2_DEF   = 2;
  localparam int PH_W           = SAM_LOG2_DEF + SYM_LOG2_DEF;
  localparam int FILL_SYMS_DEF  = 8;
  localparam int CYCLE_SYMS_DEF = 1024;
  localparam int SAM_PERIOD_DEF = 1 << SAM_LOG2_DEF;
  localparam int SYM_PERIOD_DEF = 1 << PH_W;

endpackage

// File: rtl/tx_rate_scheduler_phase_decoder.sv
// Decodes the shared phase counter into the per-stage clock enables and
// zero-stuff / interpolator selects; everything is quiet outside FILL/RUN.
module phase_decoder
  import tx_timing_pkg::*;
#(
  parameter int SAM_LOG2 = SAM_LOG2_DEF,
  parameter int SYM_LOG2 = SYM_LOG2_DEF
) (
  input  logic [SAM_LOG2+SYM_LOG2-1:0] ph,
  input  logic [1:0]                   state,
  input  logic                         hold,
  output logic                         sys_clk2_en,
  output logic                         sam_clk_en,
  output logic                         sym_clk_en,
  output logic                         stuff_sel,
  output logic                         hb1_sel,
  output logic                         hb2_sel
);

  localparam int PH_BITS = SAM_LOG2 + SYM_LOG2;

  logic en;

  always_comb begin
    en          = (state != IDLE) && !hold;
    sys_clk2_en = en & ph[0];
    sam_clk_en  = en & (&ph[SAM_LOG2-1:0]);
    sym_clk_en  = en & (&ph);
    // mapper sample is injected only in the first sample slot of each symbol
    stuff_sel   = en & (ph[PH_BITS-1 -: SYM_LOG2] == '0);
    hb1_sel     = en & ~ph[1];
    hb2_sel     = en & ph[0];
  end

endmodule

// File: rtl/tx_rate_scheduler.sv
// Transmit-chain timing controller: one phase counter drives every stage enable.
// Optional single-step hold input enabled by TX_RATE_SCHEDULER_FREEZE_EN.
//
// state | meaning
// IDLE  | stopped, phase held at 0, all enables/selects low
// FILL  | chain running, waiting FILL_SYMS symbols for the filter pipeline
// RUN   | chain running, tx_valid high, measurement cycle counted
module tx_rate_scheduler
  import tx_timing_pkg::*;
#(
  parameter int SAM_LOG2   = SAM_LOG2_DEF,
  parameter int SYM_LOG2   = SYM_LOG2_DEF,
  parameter int FILL_SYMS  = FILL_SYMS_DEF,
  parameter int CYCLE_SYMS = CYCLE_SYMS_DEF
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
`ifdef TX_RATE_SCHEDULER_FREEZE_EN
  input  logic freeze,
`endif
  output logic busy,
  output logic tx_valid,
  output logic sys_clk2_en,
  output logic sam_clk_en,
  output logic sym_clk_en,
  output logic stuff_sel,
  output logic hb1_sel,
  output logic hb2_sel,
  output logic acc_clr
);

  localparam int          PH_BITS  = SAM_LOG2 + SYM_LOG2;
  localparam logic [7:0]  SYM_LAST = 8'(FILL_SYMS - 1);
  localparam logic [21:0] CYC_LAST = 22'(CYCLE_SYMS - 1);

  tx_state_t          state, state_nxt;
  logic [PH_BITS-1:0] ph, ph_nxt;
  logic [7:0]         sym_cnt, sym_cnt_nxt;
  logic [21:0]        cyc_cnt, cyc_cnt_nxt;
  logic               stop_pend, stop_pend_nxt;
  logic               hold;

`ifdef TX_RATE_SCHEDULER_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ph        <= '0;
      sym_cnt   <= '0;
      cyc_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      sym_cnt   <= sym_cnt_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ph_nxt        = ph;
    sym_cnt_nxt   = sym_cnt;
    cyc_cnt_nxt   = cyc_cnt;
    stop_pend_nxt = stop_pend;
    case (state)
      IDLE: begin
        ph_nxt        = '0;
        sym_cnt_nxt   = '0;
        cyc_cnt_nxt   = '0;
        stop_pend_nxt = 1'b0;
        if (start && !stop) state_nxt = FILL;
      end
      FILL, RUN: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (!hold) ph_nxt = ph + PH_BITS'(1);
        // a stop only takes effect on a symbol boundary so no symbol is cut short
        if (sym_clk_en) begin
          if (stop_pend) begin
            state_nxt     = IDLE;
            ph_nxt        = '0;
            sym_cnt_nxt   = '0;
            cyc_cnt_nxt   = '0;
            stop_pend_nxt = 1'b0;
          end else if (state == FILL) begin
            if (sym_cnt == SYM_LAST) begin
              state_nxt   = RUN;
              sym_cnt_nxt = '0;
            end else begin
              sym_cnt_nxt = sym_cnt + 8'd1;
            end
          end else begin
            cyc_cnt_nxt = (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + 22'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  phase_decoder #(
    .SAM_LOG2 (SAM_LOG2),
    .SYM_LOG2 (SYM_LOG2)
  ) u_phase_decoder (
    .ph          (ph),
    .state       (state),
    .hold        (hold),
    .sys_clk2_en (sys_clk2_en),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .stuff_sel   (stuff_sel),
    .hb1_sel     (hb1_sel),
    .hb2_sel     (hb2_sel)
  );

  assign busy     = (state != IDLE);
  assign tx_valid = (state == RUN);
  assign acc_clr  = sym_clk_en && (state == RUN) && (cyc_cnt == CYC_LAST);

endmodule
